// File: rtl/fir_decim_out_if.sv
// fir_decim_out_if -- signal bundle between a FIR decimator output stage and
// its neighbours.
//   din_valid  : upstream FIR sum strobe. There is no backpressure to upstream.
//   din[28:0]  : unsigned FIR sum.
//   clr_flags  : one-cycle pulse that clears the sticky flags.
//   dout_valid : the FIFO head is valid.
//   dout_ready : downstream accepts the head.
//   dout[11:0] : rounded, saturated, decimated sample.
//   level[2:0] : FIFO occupancy, 0..4.
//   sat_flag   : sticky flag. A kept sample was saturated.
//   ovf_flag   : sticky flag. A kept sample was dropped because the FIFO was full.
// Handshake: a sample moves from dout to downstream on every rising clk edge
// where dout_valid=1 and dout_ready=1. While dout_valid=1 and dout_ready=0,
// dout holds its value. While dout_valid=0, dout_ready is ignored.
// Modports: master = the environment, which drives inputs and takes outputs.
// slave = the block itself.
interface fir_decim_out_if;
  logic        din_valid;
  logic [28:0] din;
  logic        clr_flags;
  logic        dout_valid;
  logic        dout_ready;
  logic [11:0] dout;
  logic [2:0]  level;
  logic        sat_flag;
  logic        ovf_flag;

  modport master (
    output din_valid, din, clr_flags, dout_ready,
    input  dout_valid, dout, level, sat_flag, ovf_flag
  );

  modport slave (
    input  din_valid, din, clr_flags, dout_ready,
    output dout_valid, dout, level, sat_flag, ovf_flag
  );
endinterface

// File: rtl/fir_decim_out.sv
// fir_decim_out -- output stage of a decimating FIR filter.
// The block keeps one FIR sum out of every DEC sums. It rounds and shifts each
// kept sum down by SHIFT bits, then saturates the result to 12 bits (stage 1).
// The result goes into a 4-entry FIFO (stage 2) that presents a valid/ready
// output.
// Ports:
//   clk : single clock. All state changes on its rising edge.
//   rst : asynchronous reset, active high.
//   bus : fir_decim_out_if.slave. It carries din_valid/din, clr_flags,
//         dout_valid/dout_ready/dout, level, sat_flag and ovf_flag.
// Parameters: DEC is the decimation factor (1..16). SHIFT is the right shift
// applied before rounding (1..17).
module fir_decim_out #(
  parameter int DEC   = 4,
  parameter int SHIFT = 12
) (
  input logic            clk,
  input logic            rst,
  fir_decim_out_if.slave bus
);

  localparam int          PW  = 5;
  localparam logic [29:0] RND = 30'(1) << (SHIFT - 1);

  // Decimation phase
  logic [PW-1:0] r_ph;
  logic          w_keep;

  // The first strobe after reset sees r_ph=0, so that sample is kept.
  assign w_keep = bus.din_valid && (r_ph == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph <= '0;
    end else if (bus.din_valid) begin
      r_ph <= (r_ph == PW'(DEC - 1)) ? '0 : r_ph + PW'(1);
    end
  end

  // Stage 1: round, shift and saturate
  // The sum is one bit wider than din, so adding the rounding constant never wraps.
  logic [29:0] w_sum;
  logic [29:0] w_q;
  logic        w_sat;
  logic [11:0] w_s1_data;
  logic        r_s1_valid;
  logic [11:0] r_s1_data;

  assign w_sum     = {1'b0, bus.din} + RND;
  assign w_q       = w_sum >> SHIFT;
  assign w_sat     = (w_q > 30'd4095);
  assign w_s1_data = w_sat ? 12'hFFF : w_q[11:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_keep;
      r_s1_data  <= w_s1_data;
    end
  end

  // Stage 2: 4-entry FIFO
  logic [11:0] r_mem [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_level;
  logic        w_pop;
  logic        w_push_ok;
  logic        w_drop;
  logic [1:0]  w_last_idx;

  assign w_pop     = (r_level != 3'd0) && bus.dout_ready;
  // When the FIFO is full, a pop in the same cycle makes room for the push.
  assign w_push_ok = r_s1_valid && ((r_level != 3'd4) || w_pop);
  assign w_drop    = r_s1_valid && !w_push_ok;
  // When the FIFO is empty, the entry just behind the read pointer holds the
  // last sample popped. A push only writes at the write pointer, which equals
  // the read pointer in that state, so this entry stays intact.
  assign w_last_idx = r_rptr - 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= r_s1_data;
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.dout_valid = (r_level != 3'd0);
  assign bus.dout       = (r_level == 3'd0) ? r_mem[w_last_idx] : r_mem[r_rptr];
  assign bus.level      = r_level;

  // Sticky flags. A set event wins over a clear pulse in the same cycle.
  logic r_sat;
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_sat <= (r_sat && !bus.clr_flags) || (w_keep && w_sat);
      r_ovf <= (r_ovf && !bus.clr_flags) || w_drop;
    end
  end

  assign bus.sat_flag = r_sat;
  assign bus.ovf_flag = r_ovf;

endmodule

// File: doc/fir_decim_out.md
FIR_DECIM_OUT -- requirements
Module: fir_decim_out

Interface
REQ-001 SHALL provide parameter DEC, default 4, decimation factor (legal 1..16).
REQ-002 SHALL provide parameter SHIFT, default 12, right-shift applied to the filter sum before rounding (legal 1..17).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port din_valid  input  1  upstream FIR output-valid strobe; no backpressure to upstream.
REQ-006 SHALL have port din  input  29  unsigned FIR sum.
REQ-007 SHALL have port clr_flags  input  1  one-cycle pulse that clears sticky flags.
REQ-008 SHALL have port dout_valid  output  1  FIFO head valid.
REQ-009 SHALL have port dout_ready  input  1  downstream accept.
REQ-010 SHALL have port dout  output  12  rounded, saturated, decimated sample.
REQ-011 SHALL have port level  output  3  FIFO occupancy, 0..4.
REQ-012 SHALL have port sat_flag  output  1  sticky: a kept sample was saturated.
REQ-013 SHALL have port ovf_flag  output  1  sticky: a kept sample was dropped because the FIFO was full.

Function
REQ-014 SHALL hold phase counter ph, range 0..DEC-1, incremented on every din_valid and wrapping DEC-1 -> 0.
REQ-015 SHALL keep a sample only when din_valid=1 and ph=0, so the first sample after reset is kept; DEC=1 keeps every sample.
REQ-016 SHALL round in stage 1 (registered, one cycle): q = (din + 2^(SHIFT-1)) >> SHIFT, computed 30 bits wide with no wrap.
REQ-017 SHALL saturate q > 4095 to 4095, and set sat_flag in the same stage-1 cycle.
REQ-018 SHALL push a stage-1 result into a 4-entry FIFO one cycle after stage 1 (stage 2).
REQ-019 SHALL present the FIFO head on dout/dout_valid; a kept sample reaching an empty FIFO SHALL appear with dout_valid=1 exactly 2 cycles after its din_valid cycle.
REQ-020 SHALL pop the FIFO on a cycle where dout_valid=1 and dout_ready=1; dout SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-021 SHALL, when pushing into a full FIFO (level=4) with no pop that cycle, drop the new sample, keep FIFO contents, and set ovf_flag.
REQ-022 SHALL accept the push on a simultaneous push and pop at level=4: level stays 4 and ovf_flag does not set.
REQ-023 SHALL leave level unchanged on a simultaneous push and pop at level 1..3, with the FIFO order preserved.
REQ-024 SHALL ignore dout_ready while level=0; dout_valid=0 there and dout holds its last value.
REQ-025 SHALL update level in the same cycle as push/pop, never exceeding 4 and never going below 0.
REQ-026 SHALL clear sat_flag and ovf_flag on clr_flags=1; if a set event coincides with clr_flags, the set SHALL win.
REQ-027 SHALL leave ph, the pipeline and FIFO contents unaffected by clr_flags.

Reset
REQ-028 SHALL, on rst=1, immediately force ph=0, stage-1 valid=0, FIFO empty, level=0, dout_valid=0, dout=0, sat_flag=0, ovf_flag=0, independent of clk.
REQ-029 SHALL discard any sample in flight when rst is asserted mid-operation; the first din_valid after rst deasserts SHALL be kept (ph=0).

Verification
REQ-030 SHALL cover rounding (DEC=1, SHIFT=12, dout_ready=1): din=2047 -> dout=0; din=2048 -> dout=1; din=409600 -> dout=100; each appears 2 cycles after its input.
REQ-031 SHALL cover saturation: din=16775168 -> dout=4095, sat_flag=1; din=2^29-1 -> dout=4095; clr_flags pulse -> sat_flag=0 next cycle.
REQ-032 SHALL cover decimation (DEC=4): 12 consecutive din_valid with din=k*4096, k=0..11 -> outputs exactly 0, 4, 8, in order.
REQ-033 SHALL cover backpressure/overflow (DEC=1, dout_ready=0): 5 samples 1..5 -> level=4, ovf_flag=1; then dout_ready=1 -> outputs 1, 2, 3, 4; 5 never appears.
REQ-034 SHALL cover push and pop at full: level=4, and a kept sample arrives at stage 2 in the same cycle as a pop -> level stays 4, ovf_flag stays 0, new sample emitted last.
REQ-035 SHALL cover mid-operation reset: rst=1 asserted with level=3 and one sample in stage 1 -> level=0, dout_valid=0 at once; after release, the next din_valid sample is output.
